wb_adder_slave: RTL and testbench
=================================

# wb_adder_slave

Wishbone classic slave that fronts the 8-bit adder. It replaces the direct operand tap on `wbs_dat_i` with a proper responder. The management SoC writes operands A and B into registers and reads back a registered 9-bit sum and status with a correct `wbs_ack_o` handshake. The registered sum also drives user IO pins. It sits inside `user_project_wrapper`, between the Wishbone MI A port and the IO/IRQ pins.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: slave base; decode is `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.

Ports:
- `wb_clk_i`  in  1  sole clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_cyc_i`  in  1  bus cycle.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  byte address; word offset is `[3:2]`.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  read data.
- `io_out`  out  9  registered sum `{carry, sum[7:0]}`.
- `io_oeb`  out  9  output enables, active-low; constant 0.
- `irq`  out  1  done interrupt (see Configuration).

## Operation
Register map (offset):
- 0x0 `A`: RW, bits [7:0], written only when `wbs_sel_i[0]`.
- 0x4 `B`: RW, bits [7:0], written only when `wbs_sel_i[0]`.
- 0x8 `SUM`: RO, `{23'b0, carry, sum[7:0]}`. Writes are acked and ignored.
- 0xC `CTRL`: RW.
  - Read returns `{count[15:0], 13'b0, irq_en, 1'b0, done}`.
  - Write bit0=1 clears `done`.
  - Write bit1=1 clears `count`.
  - Bit2 writes `irq_en`.
  - Bit 3 of `wbs_sel_i` is ignored; `sel[0]` gates the whole CTRL write.

Request and acknowledge:
- A request is `wbs_cyc_i & wbs_stb_i & addr match & !wbs_ack_o`.
- Requests to non-matching addresses get no ack and have no effect.
- Writes to `A`/`B`/`CTRL` commit at the clock edge that raises `wbs_ack_o`.
- Read data is registered and valid in the ack cycle. It is 0 outside the ack cycle.

Sum pipeline (two states, IDLE/UPDATE):
- A committed write to `A` or `B` moves IDLE→UPDATE.
- On the next edge: `{carry,sum} <= A + B` (9-bit, no truncation), `done <= 1`, `count <= count + 1`, `io_out` updates, then the block returns to IDLE.
- `count` wraps 0xFFFF→0x0000.
- A write with `sel[0]=0` to `A`/`B` is acked but does not update the register or trigger UPDATE.

Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `io_out`=0, `io_oeb`=0, `irq`=0. `A`, `B`, `sum`, `count`, `done` and `irq_en` are all 0.

## Timing
- Request present in cycle N → `wbs_ack_o`=1 in cycle N+1 only. This is a one-cycle pulse, even if `stb` stays high.
- Next request can be accepted in cycle N+2. Maximum throughput is one transfer per 2 cycles.
- Master drops `stb`/`cyc` after ack. If `cyc` drops before ack, the ack is still issued, and a write still commits.
- Sum latency: `A`/`B` write request in cycle N → sum, `done`, `count` and `io_out` update at the end of N+1.
  - Visible from N+2.
  - A back-to-back `SUM` read therefore returns the new value.
- A `CTRL` clear cannot coincide with an UPDATE edge, because requests are spaced at least 2 cycles apart. If it does coincide, set wins for `done` and increment wins for `count`.
- Reset asserted mid-transaction forces ack low immediately (asynchronous) and clears all state. The pending transfer is lost, and the master must retry.

## Configuration
- `ADDER_IRQ_EN` defined:
  - `irq` is registered, `irq = done & irq_en`.
  - It rises one cycle after `done` sets, and falls one cycle after the `CTRL` clear commits.
- Not defined:
  - `irq` is tied to 0.
  - `irq_en` reads as 0 and its write is ignored; no IRQ logic is synthesized.

## Test plan
- Reset: assert `wb_rst_i` asynchronously mid-cycle → `ack`, `dat_o`, `io_out` and `irq` are 0 immediately; `CTRL` reads 0x00000000.
- Add: write A=0xFF, B=0x01 → `SUM` reads 0x100, `io_out`=9'h100, `done`=1, `count`=2 (two updates).
- Handshake: hold `stb`/`cyc` high for 5 cycles → exactly one ack pulse, in cycle N+1. Non-matching address 0x4000_0000 → no ack.
- Byte select: write A=0x55 with `sel`=4'b0010 → acked, A unchanged, no `count` increment.
- Clear/wrap: preload `count` to 0xFFFF by 65535 writes, write once more → `count`=0. Write `CTRL`=0x3 → `done`=0, `count`=0.
- IRQ (with `ADDER_IRQ_EN`): `CTRL`=0x4, write B → `irq` high 1 cycle after `done`. `CTRL`=0x5 → `irq` low. Without the macro, `irq` stays 0 throughout.

Source files
------------

// File: rtl/wb_adder_slave.sv
// Wishbone classic slave holding adder operands A/B, a registered 9-bit sum,
// a done flag and an update counter. Optional done interrupt under `ADDER_IRQ_EN.
module wb_adder_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [8:0]  io_out,
    output logic [8:0]  io_oeb,
    output logic        irq
);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        served_q, served_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [8:0]  sum_q, sum_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;

    logic        hit;
    logic        req;
    logic        wr;
    logic        ctrl_wr;
    logic        ab_wr;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        irq_en_rd;
    logic        unused_bits;

    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off     = wbs_adr_i[3:2];
    // A strobe held past its ack is served only once; the master must drop it first.
    assign req     = wbs_cyc_i & wbs_stb_i & hit & ~ack_q & ~served_q;
    assign wr      = req & wbs_we_i & wbs_sel_i[0];
    assign ctrl_wr = wr & (off == 2'd3);
    assign ab_wr   = wr & ((off == 2'd0) | (off == 2'd1));

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    always_comb begin
        rdata = 32'h0;
        case (off)
            2'd0: rdata = {24'h0, a_q};
            2'd1: rdata = {24'h0, b_q};
            2'd2: rdata = {23'h0, sum_q};
            2'd3: rdata = {count_q, 13'h0, irq_en_rd, 1'b0, done_q};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = req;
        served_d = wbs_cyc_i & wbs_stb_i & (served_q | req);
        dat_d    = (req & ~wbs_we_i) ? rdata : 32'h0;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        count_d  = count_q;
        done_d   = done_q;

        if (wr && off == 2'd0) a_d = wbs_dat_i[7:0];
        if (wr && off == 2'd1) b_d = wbs_dat_i[7:0];
        if (ctrl_wr) begin
            if (wbs_dat_i[0]) done_d  = 1'b0;
            if (wbs_dat_i[1]) count_d = 16'h0;
        end

        // Update edge overrides a coincident CTRL clear (set and increment win).
        if (state_q == UPDATE) begin
            sum_d   = {1'b0, a_q} + {1'b0, b_q};
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
        end

        state_d = ab_wr ? UPDATE : IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            served_q <= 1'b0;
            dat_q    <= 32'h0;
            a_q      <= 8'h0;
            b_q      <= 8'h0;
            sum_q    <= 9'h0;
            count_q  <= 16'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            served_q <= served_d;
            dat_q    <= dat_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

`ifdef ADDER_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = wbs_dat_i[2];
        irq_d = done_q & irq_en_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq       = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign irq       = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = sum_q;
    assign io_oeb    = 9'h0;

endmodule

// File: tb/tb_wb_adder_slave.sv
// Self-checking bench for wb_adder_slave: read data is checked through a
// queue of expected values pushed at request time and popped at ack.
module tb_wb_adder_slave;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_ADR  = BASE + 32'h0;
    localparam logic [31:0] B_ADR  = BASE + 32'h4;
    localparam logic [31:0] S_ADR  = BASE + 32'h8;
    localparam logic [31:0] C_ADR  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [8:0]  io_out, io_oeb;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    wb_adder_slave #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) got = 1;
        end
        bus_idle();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL write_ack adr=%h: ack=0 required=1", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        bit got = 0;
        logic [31:0] seen = 32'h0;
        logic [31:0] want;
        string       n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                got  = 1;
                seen = dat_o;
            end
        end
        bus_idle();
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no ack, required data %h", n, want);
        end else if (seen !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, seen, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack, dat_o, io_out, io_oeb, irq} !== 52'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h io_out=%h io_oeb=%h irq=%b required all 0",
                     ack, dat_o, io_out, io_oeb, irq);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        wb_write(A_ADR, 32'h3, 4'h1);
        wb_write(B_ADR, 32'h4, 4'h1);
        checks++;
        if (io_out !== 9'h007) begin
            errors++;
            $display("FAIL pre_reset_sum: io_out=%h required 007", io_out);
        end

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = S_ADR; sel = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1 || dat_o !== 32'h7) begin
            errors++;
            $display("FAIL pre_reset_ack: ack=%b dat=%h required 1/00000007", ack, dat_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || dat_o !== 32'h0 || io_out !== 9'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ack=%b dat=%h io_out=%h irq=%b required 0",
                     ack, dat_o, io_out, irq);
        end
        bus_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(C_ADR, 32'h0, "reset_ctrl");
        wb_read(S_ADR, 32'h0, "reset_sum");
        wb_read(A_ADR, 32'h0, "reset_a");
    endtask

    task automatic test_add();
        wb_write(A_ADR, 32'hFF, 4'h1);
        wb_write(B_ADR, 32'h01, 4'h1);
        checks++;
        if (io_out !== 9'h100) begin
            errors++;
            $display("FAIL add_io_out: got %h required 100", io_out);
        end
        wb_read(S_ADR, 32'h100, "add_sum");
        wb_read(C_ADR, 32'h0002_0001, "add_ctrl");
        wb_read(A_ADR, 32'hFF, "add_a");
    endtask

    task automatic test_back_to_back();
        wb_write(A_ADR, 32'h10, 4'h1);
        wb_read(S_ADR, 32'h011, "b2b_sum_a");
        wb_write(B_ADR, 32'h80, 4'h1);
        wb_read(S_ADR, 32'h090, "b2b_sum_b");
        checks++;
        if (io_out !== 9'h090) begin
            errors++;
            $display("FAIL b2b_io_out: got %h required 090", io_out);
        end
    endtask

    task automatic test_handshake();
        int n_ack = 0;
        int first = -1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_ADR; sel = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                n_ack++;
                if (first < 0) first = i;
            end
            if (i == 1) begin
                checks++;
                if (dat_o !== 32'h0) begin
                    errors++;
                    $display("FAIL dat_after_ack: got %h required 0", dat_o);
                end
            end
        end
        bus_idle();
        @(posedge clk); #1;
        checks++;
        if (n_ack != 1 || first != 0) begin
            errors++;
            $display("FAIL held_stb_ack: acks=%0d first=%0d required 1 at 0", n_ack, first);
        end

        n_ack = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4000_0004; dat_i = 32'h77; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) n_ack++;
        end
        bus_idle();
        @(posedge clk); #1;
        checks++;
        if (n_ack != 0) begin
            errors++;
            $display("FAIL nomatch_ack: acks=%0d required 0", n_ack);
        end
        wb_read(B_ADR, 32'h80, "nomatch_b_kept");
    endtask

    task automatic test_byte_select();
        wb_write(A_ADR, 32'h55, 4'b0010);
        wb_read(A_ADR, 32'h10, "sel_a_kept");
        wb_read(C_ADR, 32'h0004_0001, "sel_no_count");
        wb_write(S_ADR, 32'h1FF, 4'hF);
        wb_read(S_ADR, 32'h090, "sum_ro");
        wb_write(C_ADR, 32'h3, 4'b1110);
        wb_read(C_ADR, 32'h0004_0001, "ctrl_sel0_gate");
    endtask

    task automatic test_clear_wrap();
        @(negedge clk);
        dut.count_q = 16'hFFFE;
        @(posedge clk); #1;
        wb_write(A_ADR, 32'h01, 4'h1);
        wb_read(C_ADR, 32'hFFFF_0001, "count_ffff");
        wb_write(A_ADR, 32'h02, 4'h1);
        wb_read(C_ADR, 32'h0000_0001, "count_wrap");
        checks++;
        if (io_out !== 9'h082) begin
            errors++;
            $display("FAIL wrap_io_out: got %h required 082", io_out);
        end
        wb_write(C_ADR, 32'h3, 4'h1);
        wb_read(C_ADR, 32'h0, "ctrl_clear");
    endtask

    task automatic test_irq();
`ifdef ADDER_IRQ_EN
        wb_write(C_ADR, 32'h4, 4'h1);
        wb_read(C_ADR, 32'h0000_0004, "irq_en_set");
        wb_write(B_ADR, 32'h01, 4'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_lag: irq=%b required 0 in done cycle", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: irq=%b required 1", irq);
        end
        wb_read(C_ADR, 32'h0001_0005, "irq_ctrl");
        wb_write(C_ADR, 32'h5, 4'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: irq=%b required 0", irq);
        end
        wb_read(C_ADR, 32'h0001_0004, "irq_cleared_ctrl");
`else
        int hi = 0;
        wb_write(C_ADR, 32'h4, 4'h1);
        wb_read(C_ADR, 32'h0, "irq_en_ignored");
        wb_write(B_ADR, 32'h01, 4'h1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (irq !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL irq_tied: high cycles=%0d required 0", hi);
        end
        wb_read(C_ADR, 32'h0001_0001, "noirq_ctrl");
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_handshake();
        test_byte_select();
        test_clear_wrap();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
